pll_phase_ctrl: RTL and testbench
=================================

# pll_phase_ctrl

Sequencer for the ECP5 EHXPLLL dynamic-phase and lock interface in the ULX3S clock tree. It accepts phase-shift requests (output select, direction, step count) from a single requester, such as a video/SDRAM calibration FSM or a CPU register. It drives PHASESEL/PHASEDIR/PHASESTEP with guaranteed setup, pulse and settle times. It also qualifies the PLL LOCK signal into a debounced lock status, a downstream synchronous-deassert system reset, and a lock-loss counter.

## Interface
Parameters:
- SETUP_CYCLES, 4: cycles PHASESEL/PHASEDIR are stable before the first PHASESTEP falling edge (>=1).
- PULSE_CYCLES, 4: PHASESTEP low time per step (>=1).
- SETTLE_CYCLES, 16: PHASESTEP high time after each step before the next step or completion (>=1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles before lock is declared good (>=2).
- STEP_W, 8: width of the step count.

Ports:
- clk  in  1  control clock, free-running, not derived from the controlled PLL.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  phase-shift request valid.
- req_ready  out  1  request accepted on a clk edge where req_valid & req_ready.
- req_sel  in  2  output select: 00 CLKOS, 01 CLKOS2, 10 CLKOS3, 11 CLKOP.
- req_dir  in  1  shift direction, passed through to PHASEDIR.
- req_steps  in  STEP_W  number of steps; 0 is legal.
- busy  out  1  request in progress.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  valid with done; 1 = request cut short by lock loss.
- pll_phasesel  out  2  to EHXPLLL PHASESEL[1:0].
- pll_phasedir  out  1  to PHASEDIR.
- pll_phasestep  out  1  to PHASESTEP; idle high.
- pll_locked  in  1  EHXPLLL LOCK; asynchronous to clk.
- lock_ok  out  1  debounced lock status.
- sys_reset  out  1  active-high reset for PLL-clocked logic; equals ~lock_ok.
- lock_loss_cnt  out  8  count of lock_ok 1->0 transitions, saturating at 255.

## Operation
- pll_locked passes through a 2-flop synchronizer to produce locked_s.
- Stability counter:
  - Counts up while locked_s=1.
  - Asserts lock_ok when the count reaches LOCK_STABLE_CYCLES, then holds.
  - locked_s=0 clears the counter and lock_ok in the same cycle.
- lock_loss_cnt increments on each lock_ok falling edge and saturates at 255.
- req_ready = lock_ok & state==IDLE.
- FSM states: IDLE, SETUP, PULSE, SETTLE, DONE.
  - IDLE: on accept, latch sel, dir and steps into pll_phasesel/pll_phasedir/remaining.
    - steps=0 -> go to DONE.
    - Otherwise -> go to SETUP.
  - SETUP: hold for SETUP_CYCLES -> PULSE.
  - PULSE: pll_phasestep=0 for PULSE_CYCLES; decrement remaining on exit -> SETTLE.
  - SETTLE: pll_phasestep=1 for SETTLE_CYCLES.
    - remaining != 0 -> PULSE.
    - Otherwise -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- pll_phasesel and pll_phasedir change only on accept; they are held between requests.
- busy=1 in SETUP, PULSE, SETTLE and DONE.
- Lock loss (lock_ok falls) in SETUP, PULSE or SETTLE:
  - Next state is DONE with aborted=1.
  - pll_phasestep returns high in that same next cycle.
  - Remaining steps are discarded.
- req_sel, req_dir and req_steps are ignored when no handshake occurs.

## Timing
- Reset values:
  - req_ready=0, busy=0, done=0, aborted=0.
  - pll_phasesel=00, pll_phasedir=0, pll_phasestep=1.
  - lock_ok=0, sys_reset=1, lock_loss_cnt=0.
  - FSM=IDLE, counters 0.
- All outputs are registered except req_ready and sys_reset, which are single-gate functions of registers.
- lock_ok rises LOCK_STABLE_CYCLES+2 cycles after pll_locked rises: 2 synchronizer cycles plus the count.
- lock_ok falls 3 cycles after pll_locked falls.
- Request accepted at edge 0 with N>0 steps:
  - PHASESTEP falls at the start of cycle SETUP_CYCLES+1.
  - Step k (0-based) falls at cycle SETUP_CYCLES+1+k*(PULSE_CYCLES+SETTLE_CYCLES).
  - done is high in cycle SETUP_CYCLES+N*(PULSE_CYCLES+SETTLE_CYCLES)+1.
  - req_ready returns in the following cycle.
  - With defaults and N=1: falling edge at cycle 5, done at cycle 25.
- steps=0: done in cycle 1, aborted=0, no PHASESTEP activity.
- A lock-loss abort never shortens PHASESTEP high time; it may only truncate a low pulse.
- Asynchronous reset mid-request forces pll_phasestep=1 and FSM=IDLE immediately, with no done pulse.

## Test plan
- Reset, then hold pll_locked=1 -> lock_ok and req_ready rise exactly 1026 cycles after reset release (defaults); sys_reset=1 until then.
- Request sel=10, dir=1, steps=3 -> phasesel=10 and phasedir=1 from cycle 1; three PHASESTEP low pulses of 4 cycles, 20 cycles apart, first at cycle 5; one done with aborted=0 at cycle 65.
- Request steps=0 -> done at cycle 1, PHASESTEP constant high, req_ready back at cycle 2.
- Drop pll_locked during the second step of a 5-step request -> PHASESTEP high within 4 cycles; done with aborted=1; lock_loss_cnt=1; sys_reset=1; req_ready stays 0 until relock plus 1026 cycles.
- Assert req_valid continuously while busy -> exactly one handshake per completed request; latched sel/dir unaffected by req_sel/req_dir changes while busy.
- Toggle pll_locked 300 times after lock_ok -> lock_loss_cnt saturates at 255; assert reset mid-PULSE -> PHASESTEP=1, all outputs at reset values asynchronously.

Source files
------------

// File: rtl/pll_phase_ctrl.sv
// Phase-step sequencer and lock qualifier for the ECP5 EHXPLLL dynamic phase interface.
// Drives PHASESEL/PHASEDIR/PHASESTEP with fixed setup/pulse/settle timing and debounces LOCK.
module pll_phase_ctrl #(
    parameter int unsigned SETUP_CYCLES       = 4,
    parameter int unsigned PULSE_CYCLES       = 4,
    parameter int unsigned SETTLE_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STEP_W             = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_sel,
    input  logic              req_dir,
    input  logic [STEP_W-1:0] req_steps,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [1:0]        pll_phasesel,
    output logic              pll_phasedir,
    output logic              pll_phasestep,
    input  logic              pll_locked,
    output logic              lock_ok,
    output logic              sys_reset,
    output logic [7:0]        lock_loss_cnt
);

    localparam int unsigned MaxPhase = (SETUP_CYCLES > PULSE_CYCLES) ?
        ((SETUP_CYCLES > SETTLE_CYCLES) ? SETUP_CYCLES : SETTLE_CYCLES) :
        ((PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES);
    localparam int unsigned CW = $clog2(MaxPhase + 1);
    localparam int unsigned LW = $clog2(LOCK_STABLE_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StSetup, StPulse, StSettle, StDone} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [1:0]        sel_q, sel_d;
    logic              dir_q, dir_d;
    logic              abort_d;
    logic              done_q, aborted_q, busy_q, step_q;
    logic [1:0]        sync_q;
    logic              locked_s;
    logic [LW-1:0]     stab_q, stab_d;
    logic              lock_ok_q, lock_ok_d;
    logic [7:0]        loss_q, loss_d;
    logic              active;

    assign locked_s = sync_q[1];

    always_comb begin
        stab_d    = stab_q;
        lock_ok_d = lock_ok_q;
        loss_d    = loss_q;
        if (!locked_s) begin
            stab_d    = '0;
            lock_ok_d = 1'b0;
        end else if (!lock_ok_q) begin
            stab_d = stab_q + LW'(1);
            if (stab_q == LW'(LOCK_STABLE_CYCLES - 1)) begin
                lock_ok_d = 1'b1;
            end
        end
        if (lock_ok_q && !lock_ok_d && loss_q != 8'hff) begin
            loss_d = loss_q + 8'd1;
        end
    end

    assign active = (state_q == StSetup) || (state_q == StPulse) || (state_q == StSettle);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        abort_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    sel_d   = req_sel;
                    dir_d   = req_dir;
                    rem_d   = req_steps;
                    cyc_d   = '0;
                    state_d = (req_steps == '0) ? StDone : StSetup;
                end
            end
            StSetup: begin
                if (cyc_q == CW'(SETUP_CYCLES - 1)) begin
                    cyc_d   = '0;
                    state_d = StPulse;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            StPulse: begin
                if (cyc_q == CW'(PULSE_CYCLES - 1)) begin
                    cyc_d   = '0;
                    rem_d   = rem_q - STEP_W'(1);
                    state_d = StSettle;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            StSettle: begin
                if (cyc_q == CW'(SETTLE_CYCLES - 1)) begin
                    cyc_d   = '0;
                    state_d = (rem_q != '0) ? StPulse : StDone;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Also catches a lock that dropped on the very edge a request was accepted.
        if (active && !lock_ok_d) begin
            state_d = StDone;
            abort_d = 1'b1;
            cyc_d   = '0;
            rem_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            stab_q    <= '0;
            lock_ok_q <= 1'b0;
            loss_q    <= '0;
            state_q   <= StIdle;
            cyc_q     <= '0;
            rem_q     <= '0;
            sel_q     <= '0;
            dir_q     <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            step_q    <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], pll_locked};
            stab_q    <= stab_d;
            lock_ok_q <= lock_ok_d;
            loss_q    <= loss_d;
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            rem_q     <= rem_d;
            sel_q     <= sel_d;
            dir_q     <= dir_d;
            done_q    <= (state_d == StDone);
            aborted_q <= abort_d;
            busy_q    <= (state_d != StIdle);
            step_q    <= (state_d != StPulse);
        end
    end

    assign req_ready     = lock_ok_q & (state_q == StIdle);
    assign sys_reset     = ~lock_ok_q;
    assign lock_ok       = lock_ok_q;
    assign lock_loss_cnt = loss_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign pll_phasesel  = sel_q;
    assign pll_phasedir  = dir_q;
    assign pll_phasestep = step_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: timing checks inline, completions checked from a scoreboard.
module tb_pll_phase_ctrl;

    localparam int unsigned S = 4;
    localparam int unsigned P = 4;
    localparam int unsigned T = 16;
    localparam int unsigned L = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_dir;
    logic [1:0] req_sel;
    logic [7:0] req_steps;
    logic       busy, done, aborted;
    logic [1:0] pll_phasesel;
    logic       pll_phasedir, pll_phasestep, pll_locked;
    logic       lock_ok, sys_reset;
    logic [7:0] lock_loss_cnt;

    pll_phase_ctrl #(
        .SETUP_CYCLES      (S),
        .PULSE_CYCLES      (P),
        .SETTLE_CYCLES     (T),
        .LOCK_STABLE_CYCLES(L),
        .STEP_W            (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_sel      (req_sel),
        .req_dir      (req_dir),
        .req_steps    (req_steps),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .pll_phasesel (pll_phasesel),
        .pll_phasedir (pll_phasedir),
        .pll_phasestep(pll_phasestep),
        .pll_locked   (pll_locked),
        .lock_ok      (lock_ok),
        .sys_reset    (sys_reset),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic       dir;
        logic       ab;
    } exp_t;

    exp_t sb[$];
    int   fall_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   dones  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: every done must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            dones++;
            chk("done_has_request", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("done_sel", pll_phasesel, e.sel);
                chk("done_dir", pll_phasedir, e.dir);
                chk("done_aborted", aborted, e.ab);
            end
        end
    end

    // One request from the accept edge until done; cycle 1 is the cycle after the accept edge.
    task automatic run_req(input logic [1:0] sel, input logic dir, input logic [7:0] steps,
                           input int drop_at, input logic ab,
                           output int done_cyc, output int low_cnt);
        logic prev;
        fall_cyc.delete();
        req_valid = 1'b1;
        req_sel   = sel;
        req_dir   = dir;
        req_steps = steps;
        sb.push_back({sel, dir, ab});
        @(negedge clk);
        chk("ready_before_req", req_ready, 1);
        tick();
        req_valid = 1'b0;
        req_sel   = ~sel;
        req_dir   = ~dir;
        req_steps = 8'd7;
        prev      = 1'b1;
        done_cyc  = -1;
        low_cnt   = 0;
        for (int k = 1; k <= 400 && done_cyc < 0; k++) begin
            if (k > 1) tick();
            if (k == drop_at) pll_locked = 1'b0;
            @(negedge clk);
            if (k == 1) begin
                chk("sel_cycle1", pll_phasesel, sel);
                chk("dir_cycle1", pll_phasedir, dir);
            end
            if (pll_phasestep === 1'b0) low_cnt++;
            if (prev === 1'b1 && pll_phasestep === 1'b0) fall_cyc.push_back(k);
            prev = pll_phasestep;
            if (done === 1'b1) done_cyc = k;
        end
    endtask

    task automatic relock_check(input string tag);
        pll_locked = 1'b1;
        repeat (L + 1) tick();
        chk({tag, "_lock_early"}, lock_ok, 0);
        chk({tag, "_ready_early"}, req_ready, 0);
        tick();
        chk({tag, "_lock_ok"}, lock_ok, 1);
        chk({tag, "_ready"}, req_ready, 1);
        chk({tag, "_sys_reset"}, sys_reset, 0);
    endtask

    initial begin
        int dc, lc, hs, d0;
        logic [1:0] last_sel;
        logic       last_dir;

        reset      = 1'b1;
        pll_locked = 1'b0;
        req_valid  = 1'b0;
        req_sel    = 2'b00;
        req_dir    = 1'b0;
        req_steps  = 8'd0;
        #3;
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_sel", pll_phasesel, 0);
        chk("rst_dir", pll_phasedir, 0);
        chk("rst_step", pll_phasestep, 1);
        chk("rst_lock_ok", lock_ok, 0);
        chk("rst_sys_reset", sys_reset, 1);
        chk("rst_loss", lock_loss_cnt, 0);
        repeat (2) tick();
        reset = 1'b0;

        // Lock qualification: L+2 edges from release with LOCK already high.
        relock_check("init");

        // Three steps: falls at 5/25/45, 4 low cycles each, done at 65.
        run_req(2'b10, 1'b1, 8'd3, 0, 1'b0, dc, lc);
        chk("n3_done_cycle", dc, S + 3 * (P + T) + 1);
        chk("n3_falls", fall_cyc.size(), 3);
        for (int i = 0; i < 3 && i < fall_cyc.size(); i++) begin
            chk("n3_fall_cycle", fall_cyc[i], S + 1 + i * (P + T));
        end
        chk("n3_low_cycles", lc, 3 * P);
        tick();
        chk("n3_ready_after", req_ready, 1);
        chk("n3_busy_after", busy, 0);
        chk("n3_sel_held", pll_phasesel, 2'b10);
        chk("n3_dir_held", pll_phasedir, 1);

        // Zero steps: done in cycle 1, no PHASESTEP activity.
        run_req(2'b01, 1'b0, 8'd0, 0, 1'b0, dc, lc);
        chk("n0_done_cycle", dc, 1);
        chk("n0_falls", fall_cyc.size(), 0);
        chk("n0_low_cycles", lc, 0);
        tick();
        chk("n0_ready_cycle2", req_ready, 1);

        // req_valid held high across requests: one handshake per request, latched fields stable.
        d0        = dones;
        hs        = 0;
        last_sel  = 2'b00;
        last_dir  = 1'b0;
        req_valid = 1'b1;
        req_steps = 8'd1;
        req_sel   = 2'(($urandom));
        req_dir   = 1'($urandom);
        for (int k = 0; k < 2 * (S + P + T + 2); k++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                hs++;
                last_sel = req_sel;
                last_dir = req_dir;
                sb.push_back({req_sel, req_dir, 1'b0});
            end else if (busy === 1'b1) begin
                chk("busy_sel_stable", pll_phasesel, last_sel);
                chk("busy_dir_stable", pll_phasedir, last_dir);
            end
            tick();
            req_sel = 2'($urandom);
            req_dir = 1'($urandom);
        end
        req_valid = 1'b0;
        tick();
        chk("cont_handshakes", hs, 2);
        chk("cont_dones", dones - d0, 2);

        // Lock lost during the second pulse of a 5-step request.
        run_req(2'b11, 1'b1, 8'd5, S + 1 + P + T, 1'b1, dc, lc);
        chk("abort_done_cycle", dc, S + 1 + P + T + 3);
        chk("abort_falls", fall_cyc.size(), 2);
        chk("abort_low_cycles", lc, P + 3);
        chk("abort_step_high", pll_phasestep, 1);
        chk("abort_loss_cnt", lock_loss_cnt, 1);
        chk("abort_sys_reset", sys_reset, 1);
        chk("abort_ready", req_ready, 0);
        tick();
        chk("abort_idle", busy, 0);
        relock_check("abort");

        // lock_ok falls exactly 3 edges after LOCK falls.
        pll_locked = 1'b0;
        repeat (2) tick();
        chk("fall_lock_early", lock_ok, 1);
        tick();
        chk("fall_lock_ok", lock_ok, 0);
        chk("fall_loss_cnt", lock_loss_cnt, 2);
        relock_check("fall");

        // Saturation of the lock-loss counter.
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            repeat (3) tick();
            pll_locked = 1'b1;
            repeat (L + 2) tick();
        end
        chk("sat_loss_cnt", lock_loss_cnt, 255);
        chk("sat_lock_ok", lock_ok, 1);

        // Asynchronous reset in the middle of a PHASESTEP low pulse.
        req_valid = 1'b1;
        req_sel   = 2'b11;
        req_dir   = 1'b1;
        req_steps = 8'd3;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        chk("mid_pulse_low", pll_phasestep, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_step", pll_phasestep, 1);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sel", pll_phasesel, 0);
        chk("arst_dir", pll_phasedir, 0);
        chk("arst_lock_ok", lock_ok, 0);
        chk("arst_sys_reset", sys_reset, 1);
        chk("arst_loss", lock_loss_cnt, 0);
        chk("arst_ready", req_ready, 0);
        d0 = dones;
        repeat (3) tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("arst_no_done", dones - d0, 0);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
